// File: rtl/tpu_sram_pkg.sv
// Shared constants and types for the activation/result SRAM feeders.
//   ADDR_W      : SRAM word-address width
//   DEPTH       : number of physical SRAM words (highest legal address DEPTH-1)
//   CNT_W       : width of a job's byte count
//   MASK_B0..B3 : one-hot byte-lane write masks
//   MASK_CLR    : all-zero mask, makes the SRAM clear the whole word
//   state_t     : byte packer FSM states
package tpu_sram_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CNT_W  = 12;

  localparam logic [3:0] MASK_B0  = 4'b0001;
  localparam logic [3:0] MASK_B1  = 4'b0010;
  localparam logic [3:0] MASK_B2  = 4'b0100;
  localparam logic [3:0] MASK_B3  = 4'b1000;
  localparam logic [3:0] MASK_CLR = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/sram_byte_packer.sv
// Write-side feeder for the 256x32b byte-maskable SRAM. Packs a signed 8-bit
// valid/ready byte stream into 32-bit words (byte 0 in bits [7:0]), issuing one
// single-lane write per accepted byte. Optionally zeroes the destination word
// range first using the SRAM's clear-on-all-zero-mask behaviour.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : job request, sampled only in IDLE
//   base_addr          : first destination word
//   byte_count         : bytes in the job (0 = empty job, done only)
//   clear_en           : zero destination words before writing
//   in_valid/in_data   : input byte stream
//   in_ready           : a byte is accepted this cycle
//   sram_csb/sram_wsb  : SRAM chip select / write enable, active low
//   sram_bytemask      : one-hot lane select, 4'b0000 clears the word
//   sram_waddr/wdata   : SRAM write address / write byte
//   busy               : job in CLEAR or WRITE
//   done               : one-cycle completion pulse
//   err                : one-cycle pulse for a rejected (out-of-range) start
module sram_byte_packer
  import tpu_sram_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  byte_count,
  input  logic              clear_en,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              sram_csb,
  output logic              sram_wsb,
  output logic [3:0]        sram_bytemask,
  output logic [ADDR_W-1:0] sram_waddr,
  output logic [7:0]        sram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Word count needs one bit less than the byte count; the range check needs
  // one bit more so base + words - 1 cannot wrap.
  localparam int unsigned WRD_W = CNT_W - 1;
  localparam int unsigned CHK_W = CNT_W + 1;

  state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_base,     w_base_nxt;
  logic [CNT_W-1:0]  r_count,    w_count_nxt;
  logic [WRD_W-1:0]  r_words,    w_words_nxt;
  logic [WRD_W-1:0]  r_clr_idx,  w_clr_idx_nxt;
  logic [CNT_W-1:0]  r_byte_idx, w_byte_idx_nxt;

  logic              r_csb,   w_csb_nxt;
  logic              r_wsb,   w_wsb_nxt;
  logic [3:0]        r_mask,  w_mask_nxt;
  logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
  logic [7:0]        r_wdata, w_wdata_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_busy,  w_busy_nxt;
  logic              r_done,  w_done_nxt;
  logic              r_err,   w_err_nxt;

  logic [WRD_W-1:0]  w_words;
  logic [CHK_W-1:0]  w_last_addr;
  logic              w_range_bad;
  logic [3:0]        w_lane_mask;
  logic              w_hs;

  always_comb begin
    w_words     = WRD_W'((CHK_W'(byte_count) + CHK_W'(3)) >> 2);
    w_last_addr = CHK_W'(base_addr) + CHK_W'(w_words) - CHK_W'(1);
    w_range_bad = (w_last_addr > CHK_W'(DEPTH - 1));
    w_hs        = r_ready & in_valid;
    case (r_byte_idx[1:0])
      2'd0:    w_lane_mask = MASK_B0;
      2'd1:    w_lane_mask = MASK_B1;
      2'd2:    w_lane_mask = MASK_B2;
      default: w_lane_mask = MASK_B3;
    endcase
  end

  // All outputs are registered, so this block computes the values they take
  // in the cycle after the edge, i.e. the next-state view of every output.
  always_comb begin
    w_state_nxt    = r_state;
    w_base_nxt     = r_base;
    w_count_nxt    = r_count;
    w_words_nxt    = r_words;
    w_clr_idx_nxt  = r_clr_idx;
    w_byte_idx_nxt = r_byte_idx;
    w_csb_nxt      = 1'b1;
    w_wsb_nxt      = 1'b1;
    w_mask_nxt     = r_mask;
    w_waddr_nxt    = r_waddr;
    w_wdata_nxt    = r_wdata;
    w_ready_nxt    = 1'b0;
    w_busy_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    w_err_nxt      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_base_nxt     = base_addr;
          w_count_nxt    = byte_count;
          w_words_nxt    = w_words;
          w_byte_idx_nxt = '0;
          if (byte_count == '0) begin
            w_state_nxt = ST_DONE;
          end else if (w_range_bad) begin
            w_err_nxt = 1'b1;
          end else if (clear_en) begin
            // First clear goes out in the same edge as the state change.
            w_state_nxt   = ST_CLEAR;
            w_busy_nxt    = 1'b1;
            w_csb_nxt     = 1'b0;
            w_wsb_nxt     = 1'b0;
            w_mask_nxt    = MASK_CLR;
            w_waddr_nxt   = base_addr;
            w_wdata_nxt   = '0;
            w_clr_idx_nxt = WRD_W'(1);
          end else begin
            w_state_nxt = ST_WRITE;
            w_busy_nxt  = 1'b1;
            w_ready_nxt = 1'b1;
          end
        end
      end

      ST_CLEAR: begin
        w_busy_nxt = 1'b1;
        if (r_clr_idx == r_words) begin
          w_state_nxt = ST_WRITE;
          w_ready_nxt = 1'b1;
        end else begin
          w_csb_nxt     = 1'b0;
          w_wsb_nxt     = 1'b0;
          w_mask_nxt    = MASK_CLR;
          w_waddr_nxt   = r_base + ADDR_W'(r_clr_idx);
          w_wdata_nxt   = '0;
          w_clr_idx_nxt = r_clr_idx + WRD_W'(1);
        end
      end

      ST_WRITE: begin
        w_busy_nxt  = 1'b1;
        w_ready_nxt = 1'b1;
        if (w_hs) begin
          w_csb_nxt      = 1'b0;
          w_wsb_nxt      = 1'b0;
          w_mask_nxt     = w_lane_mask;
          w_waddr_nxt    = r_base + ADDR_W'(r_byte_idx >> 2);
          w_wdata_nxt    = in_data;
          w_byte_idx_nxt = r_byte_idx + CNT_W'(1);
          if (r_byte_idx == r_count - CNT_W'(1)) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_ready_nxt = 1'b0;
          end
        end
      end

      ST_DONE: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_count    <= '0;
      r_words    <= '0;
      r_clr_idx  <= '0;
      r_byte_idx <= '0;
      r_csb      <= 1'b1;
      r_wsb      <= 1'b1;
      r_mask     <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_base     <= w_base_nxt;
      r_count    <= w_count_nxt;
      r_words    <= w_words_nxt;
      r_clr_idx  <= w_clr_idx_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_csb      <= w_csb_nxt;
      r_wsb      <= w_wsb_nxt;
      r_mask     <= w_mask_nxt;
      r_waddr    <= w_waddr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign in_ready      = r_ready;
  assign sram_csb      = r_csb;
  assign sram_wsb      = r_wsb;
  assign sram_bytemask = r_mask;
  assign sram_waddr    = r_waddr;
  assign sram_wdata    = r_wdata;
  assign busy          = r_busy;
  assign done          = r_done;
  assign err           = r_err;

endmodule
